// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// ID/EX issue stage that sits directly in front of the combinational ALU.
// Decoded instructions arrive over a valid/ready handshake. The stage picks
// the operands (register, PC or immediate), resolves RAW hazards against the
// instruction it currently holds and against the writeback port, and then
// registers op_1/op_2/opcode/rd for the ALU. Shift amounts are masked to
// 5 bits. A saturating counter records the cycles in which decode was stalled.
//
// Optional feature macro: ALU_ISSUE_FWD_EN
//   defined   : forwarding, with alu_result_in taking priority over
//               wb_data_in and wb_data_in taking priority over the register file
//   undefined : no forwarding; a RAW hazard interlocks decode instead
//
// Ports
//   clk_in, rst_in                   clock (rising edge), async active-high reset
//   valid_in / ready_out             decode -> stage handshake
//   rs1_addr_in, rs2_addr_in         source register indices
//   rs1_data_in, rs2_data_in         register file read data
//   pc_in, imm_in                    instruction PC, sign-extended immediate
//   op1_sel_in                       0 = rs1, 1 = PC
//   op2_sel_in                       0 = rs2, 1 = imm
//   alu_opcode_in, rd_addr_in        ALU opcode, destination (0 = none)
//   flush_in                         kill the held and the offered instruction
//   alu_result_in                    ALU result of the held instruction
//   wb_we_in, wb_rd_addr_in,
//   wb_data_in                       writeback port
//   valid_out / ready_in             stage -> ALU handshake
//   op_1_out, op_2_out, opcode_out,
//   rd_addr_out                      registered ALU operands
//   stall_cnt_out                    saturating stall count
module alu_issue_stage #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic [4:0]             rs1_addr_in,
  input  logic [4:0]             rs2_addr_in,
  input  logic [XLEN-1:0]        rs1_data_in,
  input  logic [XLEN-1:0]        rs2_data_in,
  input  logic [XLEN-1:0]        pc_in,
  input  logic [XLEN-1:0]        imm_in,
  input  logic                   op1_sel_in,
  input  logic                   op2_sel_in,
  input  logic [3:0]             alu_opcode_in,
  input  logic [4:0]             rd_addr_in,
  input  logic                   flush_in,
  input  logic [XLEN-1:0]        alu_result_in,
  input  logic                   wb_we_in,
  input  logic [4:0]             wb_rd_addr_in,
  input  logic [XLEN-1:0]        wb_data_in,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [XLEN-1:0]        op_1_out,
  output logic [XLEN-1:0]        op_2_out,
  output logic [3:0]             opcode_out,
  output logic [4:0]             rd_addr_out,
  output logic [STALL_CNT_W-1:0] stall_cnt_out
);

  localparam logic [4:0] REG_X0  = 5'd0;
  localparam logic [3:0] OPC_SLL = 4'b0001;
  localparam logic [3:0] OPC_SRL = 4'b0101;
  localparam logic [3:0] OPC_SRA = 4'b1101;

  // For shift opcodes only the low 5 bits of op_2 are meaningful.
  function automatic logic [XLEN-1:0] mask_shamt(input logic [XLEN-1:0] val,
                                                 input logic [3:0]      opc);
    logic [XLEN-1:0] res;
    res = val;
    if (opc == OPC_SLL || opc == OPC_SRL || opc == OPC_SRA)
      res = {{(XLEN-5){1'b0}}, val[4:0]};
    return res;
  endfunction

  // The counter stops at all-ones and never wraps.
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + STALL_CNT_W'(1);
  endfunction

  logic                   vld_p1;
  logic [XLEN-1:0]        op1_p1;
  logic [XLEN-1:0]        op2_p1;
  logic [3:0]             opc_p1;
  logic [4:0]             rd_p1;
  logic [STALL_CNT_W-1:0] stall_cnt_p1;

  logic                   handoff;
  logic                   accept;
  logic                   interlock;
  logic                   rs1_used;
  logic                   rs2_used;
  logic [XLEN-1:0]        rs1_val;
  logic [XLEN-1:0]        rs2_val;
  logic [XLEN-1:0]        op1_p0;
  logic [XLEN-1:0]        op2_p0;

  assign handoff  = vld_p1 && ready_in;
  // x0 is never a hazard source; its operand always comes from the register file.
  assign rs1_used = !op1_sel_in && (rs1_addr_in != REG_X0);
  assign rs2_used = !op2_sel_in && (rs2_addr_in != REG_X0);

`ifdef ALU_ISSUE_FWD_EN
  // The held instruction only delivers its result in the cycle it hands off.
  // If it is not handing off, ready_out is already low and nothing is accepted.
  always_comb begin
    rs1_val = rs1_data_in;
    if (rs1_used && handoff && rd_p1 == rs1_addr_in)
      rs1_val = alu_result_in;
    else if (rs1_used && wb_we_in && wb_rd_addr_in == rs1_addr_in)
      rs1_val = wb_data_in;

    rs2_val = rs2_data_in;
    if (rs2_used && handoff && rd_p1 == rs2_addr_in)
      rs2_val = alu_result_in;
    else if (rs2_used && wb_we_in && wb_rd_addr_in == rs2_addr_in)
      rs2_val = wb_data_in;
  end

  assign interlock = 1'b0;
`else
  logic main_hit;
  logic wb_hit;
  logic unused_fwd;

  assign rs1_val = rs1_data_in;
  assign rs2_val = rs2_data_in;

  // A used source that is still in flight holds decode until the register file has it.
  assign main_hit  = vld_p1 && ((rs1_used && rd_p1 == rs1_addr_in) ||
                                (rs2_used && rd_p1 == rs2_addr_in));
  assign wb_hit    = wb_we_in && ((rs1_used && wb_rd_addr_in == rs1_addr_in) ||
                                  (rs2_used && wb_rd_addr_in == rs2_addr_in));
  assign interlock = valid_in && (main_hit || wb_hit);

  assign unused_fwd = ^{alu_result_in, wb_data_in};
`endif

  // During a flush, ready_out reads high so that decode retires the killed slot.
  assign ready_out = flush_in || ((!vld_p1 || ready_in) && !interlock);
  assign accept    = valid_in && ready_out && !flush_in;

  assign op1_p0 = op1_sel_in ? pc_in : rs1_val;
  assign op2_p0 = mask_shamt(op2_sel_in ? imm_in : rs2_val, alu_opcode_in);

  // ---- p0 -> p1: operand select / forward -> ALU holding register ----
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vld_p1       <= 1'b0;
      op1_p1       <= '0;
      op2_p1       <= '0;
      opc_p1       <= '0;
      rd_p1        <= '0;
      stall_cnt_p1 <= '0;
    end else begin
      if (flush_in)
        vld_p1 <= 1'b0;
      else if (accept)
        vld_p1 <= 1'b1;
      else if (handoff)
        vld_p1 <= 1'b0;

      if (accept) begin
        op1_p1 <= op1_p0;
        op2_p1 <= op2_p0;
        opc_p1 <= alu_opcode_in;
        rd_p1  <= rd_addr_in;
      end

      if (valid_in && !ready_out && !flush_in)
        stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end
  end

  assign valid_out     = vld_p1;
  assign op_1_out      = op1_p1;
  assign op_2_out      = op2_p1;
  assign opcode_out    = opc_p1;
  assign rd_addr_out   = rd_p1;
  assign stall_cnt_out = stall_cnt_p1;

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX pipeline stage sitting directly upstream of the combinational ALU. Accepts decoded instructions over a valid/ready handshake, selects operands (register, PC or immediate), resolves RAW hazards against the in-flight ALU instruction and the writeback port, and registers `op_1`/`op_2`/opcode for the ALU. It also masks shift amounts to 5 bits and keeps a saturating stall counter.

## Interface
- `XLEN`, default 32: datapath width.
- `STALL_CNT_W`, default 16: stall counter width.

Ports:
- `clk_in`  in  1  single clock, rising edge.
- `rst_in`  in  1  asynchronous, active-high reset.
- `valid_in`  in  1  decode offers an instruction.
- `ready_out`  out  1  stage accepts this cycle.
- `rs1_addr_in`, `rs2_addr_in`  in  5  source register indices.
- `rs1_data_in`, `rs2_data_in`  in  XLEN  register file read data.
- `pc_in`  in  XLEN  instruction PC.
- `imm_in`  in  XLEN  sign-extended immediate.
- `op1_sel_in`  in  1  0 = rs1, 1 = PC.
- `op2_sel_in`  in  1  0 = rs2, 1 = imm.
- `alu_opcode_in`  in  4  ALU opcode.
- `rd_addr_in`  in  5  destination register (0 = none).
- `flush_in`  in  1  kill the in-flight instruction and the offered one.
- `alu_result_in`  in  XLEN  ALU result for the instruction currently held.
- `wb_we_in`  in  1  writeback valid.
- `wb_rd_addr_in`  in  5  writeback destination.
- `wb_data_in`  in  XLEN  writeback data.
- `valid_out`  out  1  ALU operands valid.
- `ready_in`  in  1  downstream consumes this cycle.
- `op_1_out`, `op_2_out`  out  XLEN  ALU operands.
- `opcode_out`  out  4  ALU opcode.
- `rd_addr_out`  out  5  destination register.
- `stall_cnt_out`  out  STALL_CNT_W  saturating stall count.

## Operation
- **Single holding register** ("main"). There are two states:
  - EMPTY (`valid_out` = 0).
  - FULL (`valid_out` = 1).
- **Handoff:** occurs when `valid_out && ready_in`.
- **Accept:** occurs when `valid_in && ready_out && !flush_in`.
- **State transitions:**
  - EMPTY to FULL on accept.
  - FULL to FULL on handoff and accept in the same cycle.
  - FULL to EMPTY on handoff without accept.
  - FULL stays FULL when there is no handoff.
- **Operand use:**
  - rs1 is used only when `op1_sel_in` = 0.
  - rs2 is used only when `op2_sel_in` = 0.
  - Register 0 is never a hazard source and never forwarded; its operand is taken from `rs*_data_in`.
- **Forwarding priority per used operand:**
  1. `alu_result_in`, if main is FULL, handing off this cycle, main rd = rs, and rd ≠ 0.
  2. `wb_data_in`, if `wb_we_in` and `wb_rd_addr_in` = rs ≠ 0.
  3. `rs*_data_in`.
- **Ready:** `ready_out = !valid_out || ready_in`, combinational.
- **Shift masking:** for opcodes 4'b0001, 4'b0101 and 4'b1101, the registered `op_2_out` is `{27'b0, op2[4:0]}`. All other opcodes pass `op_2` unchanged.
- **Flush:**
  - Clears `valid_out` at the next edge.
  - Discards any offered instruction; `ready_out` reads 1 during flush so decode retires the slot.
  - Flush has priority over accept and handoff.
- **Stall counter:**
  - Increments each cycle `valid_in && !ready_out && !flush_in`.
  - Saturates at all-ones and never wraps.
- **Reset mid-operation:** immediately drops `valid_out`; the held instruction is lost.

## Timing
- **Reset values:**
  - `valid_out` = 0.
  - `op_1_out`, `op_2_out` = 0.
  - `opcode_out` = 0 (ADD).
  - `rd_addr_out` = 0.
  - `stall_cnt_out` = 0.
  - `ready_out` = 1, following from `valid_out` = 0.
- **Latency:** 1 cycle from accept to `valid_out`. Throughput is one instruction per cycle when `ready_in` is held high.
- **Output stability:** outputs hold while `valid_out && !ready_in`.
- **Timing path:** `ready_out` and the forwarding muxes depend combinationally on `ready_in` and `alu_result_in` (ALU depth plus one mux to the register D input).
- **Writeback contract:** the writeback port carries an ALU instruction in the cycle after its handoff. No other in-flight producers exist between the ALU and writeback.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: forwarding as described above.
- Undefined: no forwarding; both operands come from `rs*_data_in` or PC/imm.
  - A used operand that matches main rd (main FULL, rd ≠ 0) or `wb_rd_addr_in` (`wb_we_in`, rd ≠ 0) is an interlock.
  - During an interlock, `ready_out` = 0 and a bubble is inserted when main hands off.
  - These interlock cycles count as stalls.

## Test plan
- **Dependent ADD, forwarding on:**
  - Stimulus: issue x1 = 5 + 7 (op1 = 5, op2 = imm 7); next cycle issue x2 = x1 + x1 with `rs1_data_in` = 0 (stale), `ready_in` = 1.
  - Required: second issue has `op_1_out` = `op_2_out` = 12, with no bubble.
- **Shift mask:**
  - Stimulus: opcode 4'b0001, imm = 32'h0000_0123.
  - Required: `op_2_out` = 32'h0000_0003.
  - Stimulus: opcode 4'b0000 with the same imm.
  - Required: `op_2_out` = 32'h123.
- **Backpressure and stall count:**
  - Stimulus: hold `ready_in` = 0 for 4 cycles with `valid_in` = 1 and the stage FULL.
  - Required: outputs are stable, `ready_out` = 0, `stall_cnt_out` = 4.
  - Stimulus: release `ready_in`.
  - Required: next instruction appears one cycle later.
- **Flush:**
  - Stimulus: stage FULL, `flush_in` = 1 with `valid_in` = 1.
  - Required: next cycle `valid_out` = 0, the offered instruction never appears, and the counter is unchanged.
- **Async reset mid-stall:**
  - Stimulus: assert `rst_in` between clock edges.
  - Required: `valid_out` = 0 and `stall_cnt_out` = 0 immediately, all operand outputs = 0.
- **Forwarding off (macro undefined):**
  - Stimulus: back-to-back x1 then x2 = x1 + 1.
  - Required: exactly 2 interlock cycles (main, then wb), `stall_cnt_out` = 2, and x2 issues with `rs1_data_in` from the register file.
  - Stimulus: the same sequence with rd = x0.
  - Required: no stall.
